// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder: controller states and the
// default operand width.
package bsa_pkg;

    localparam int BSA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bsa_state_e;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Request/result bundle of the bit-serial adder. The master side issues
// operands and start; the slave side (the adder) returns busy/done/sum/cout.
interface bit_serial_adder_if
    import bsa_pkg::*;
#(
    parameter int WIDTH = BSA_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/full_add_cell.sv
// Combinational 1-bit full adder; the only arithmetic element of the serial
// datapath.
module full_add_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    // Propagate term shared by the sum and carry equations
    always_comb begin
        p  = x ^ y;
        s  = p ^ ci;
        co = (x & y) | (ci & p);
    end
endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first,
// through a single full-add cell and a carry flop. done pulses for one cycle
// when the result is complete; sum/cout hold until the next accepted start.
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int WIDTH = BSA_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    bit_serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    bsa_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             cell_s;
    logic             cell_co;

    full_add_cell u_cell (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    // Next-state and datapath update: load on accept, shift one bit per SHIFT cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sum_d   = {cell_s, sum_q[WIDTH-1:1]};
                carry_d = cell_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                // The counter stops at the last bit index rather than wrapping
                if (cnt_q == LAST_BIT) begin
                    cout_d  = cell_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: an 8-bit instance for the main
// scenarios and a 2-bit instance for an exhaustive sweep, both compared with
// plain integer addition.
module tb_bit_serial_adder;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    bit_serial_adder_if #(.WIDTH(8)) bus8 ();
    bit_serial_adder_if #(.WIDTH(2)) bus2 ();

    bit_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    bit_serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer sum, result is (WIDTH+1) bits {cout,sum}
    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int unsigned r;
        r = int'(a) + int'(b) + int'(cin);
        return 9'(r % 512);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one 8-bit operation; scramble operands after accept; wait for done
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output logic [7:0] s, output logic co, output int lat,
                          output int bcyc, output logic overlap, output logic done_after);
        bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
        lat = 0; bcyc = 0;
        while (bus8.done !== 1'b1 && lat < 64) begin
            if (bus8.busy === 1'b1) bcyc++;
            step();
            lat++;
        end
        overlap = bus8.busy;
        s = bus8.sum; co = bus8.cout;
        step();
        done_after = bus8.done;
    endtask

    task automatic do_op2(input logic [1:0] a, input logic [1:0] b, input logic cin,
                          output logic [1:0] s, output logic co, output int lat);
        bus2.a = a; bus2.b = b; bus2.cin = cin; bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        bus2.a = 2'($urandom); bus2.b = 2'($urandom); bus2.cin = 1'($urandom);
        lat = 0;
        while (bus2.done !== 1'b1 && lat < 64) begin
            step();
            lat++;
        end
        s = bus2.sum; co = bus2.cout;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_tests++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus8.busy); end
        n_tests++; if (bus8.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus8.done); end
        n_tests++; if (bus8.sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", bus8.sum); end
        n_tests++; if (bus8.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", bus8.cout); end
        n_tests++; if (bus2.busy !== 1'b0 || bus2.done !== 1'b0) begin n_fail++; $display("FAIL reset_w2: busy %b done %b want 0 0", bus2.busy, bus2.done); end
        rst = 1'b0;
        step();
    endtask

    task automatic check_op8(input string name, input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [7:0] s; logic co; int lat; int bcyc; logic ov; logic da;
        logic [8:0] exp;
        exp = model8(a, b, cin);
        do_op8(a, b, cin, s, co, lat, bcyc, ov, da);
        n_tests++; if ({co, s} !== exp) begin n_fail++; $display("FAIL %s_result: a=%h b=%h cin=%b got %h want %h", name, a, b, cin, {co, s}, exp); end
        n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL %s_latency: got %0d want 8", name, lat); end
        n_tests++; if (bcyc !== 8) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d want 8", name, bcyc); end
        n_tests++; if (ov !== 1'b0) begin n_fail++; $display("FAIL %s_busy_with_done: got %b want 0", name, ov); end
        n_tests++; if (da !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse_len: done after pulse %b want 0", name, da); end
        n_tests++; if ({bus8.cout, bus8.sum} !== exp) begin n_fail++; $display("FAIL %s_hold: got %h want %h", name, {bus8.cout, bus8.sum}, exp); end
    endtask

    task automatic test_basic();
        check_op8("basic", 8'h0F, 8'h01, 1'b0);
        check_op8("back_to_back", 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic test_carry();
        check_op8("carry_ff01", 8'hFF, 8'h01, 1'b0);
        check_op8("carry_ffff1", 8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            check_op8("random", 8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_start_held();
        int acc[$];
        logic prev_busy;
        logic [8:0] exp;
        int w;
        exp = model8(8'h55, 8'hAA, 1'b0);
        bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'hAA; bus8.cin = 1'b0;
        prev_busy = bus8.busy;
        for (int c = 0; c < 45; c++) begin
            step();
            if (bus8.busy === 1'b1 && prev_busy !== 1'b1) acc.push_back(c);
            if (bus8.done === 1'b1) begin
                n_tests++; if ({bus8.cout, bus8.sum} !== exp) begin n_fail++; $display("FAIL held_result: got %h want %h", {bus8.cout, bus8.sum}, exp); end
                n_tests++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL held_busy_with_done: got %b want 0", bus8.busy); end
            end
            prev_busy = bus8.busy;
            if (bus8.busy === 1'b1) begin
                bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
            end else begin
                bus8.a = 8'h55; bus8.b = 8'hAA; bus8.cin = 1'b0;
            end
        end
        n_tests++; if (acc.size() !== 5) begin n_fail++; $display("FAIL held_accept_count: got %0d want 5", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            n_tests++; if (acc[i] - acc[i-1] !== 10) begin n_fail++; $display("FAIL held_accept_gap: got %0d want 10", acc[i] - acc[i-1]); end
        end
        bus8.start = 1'b0;
        w = 0;
        while ((bus8.busy === 1'b1 || bus8.done === 1'b1) && w < 40) begin step(); w++; end
        n_tests++; if (w >= 40) begin n_fail++; $display("FAIL held_drain_timeout: waited %0d want <40", w); end
    endtask

    task automatic test_reset_mid();
        int dones;
        bus8.a = 8'h3C; bus8.b = 8'h0F; bus8.cin = 1'b0; bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        step(); step(); step();
        n_tests++; if (bus8.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b want 1", bus8.busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus8.busy); end
        n_tests++; if (bus8.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", bus8.done); end
        n_tests++; if ({bus8.cout, bus8.sum} !== 9'h000) begin n_fail++; $display("FAIL midrst_result: got %h want 000", {bus8.cout, bus8.sum}); end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
        end
        n_tests++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles want 0", dones); end
    endtask

    task automatic test_rst_start();
        rst = 1'b1; bus8.start = 1'b1; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'b1;
        step();
        n_tests++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_busy: got %b want 0", bus8.busy); end
        rst = 1'b0; bus8.start = 1'b0;
        step();
        n_tests++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin n_fail++; $display("FAIL rst_start_idle: busy %b done %b want 0 0", bus8.busy, bus8.done); end
        check_op8("after_rst_start", 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic test_exhaustive_w2();
        logic [1:0] s; logic co; int lat; int exp;
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp = ai + bi + ci;
                    do_op2(2'(ai), 2'(bi), 1'(ci), s, co, lat);
                    n_tests++; if (int'({co, s}) !== exp) begin n_fail++; $display("FAIL w2_result: a=%0d b=%0d cin=%0d got %0d want %0d", ai, bi, ci, {co, s}, exp); end
                    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL w2_latency: got %0d want 2", lat); end
                end
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_random();
        test_start_held();
        test_reset_mid();
        test_rst_start();
        test_exhaustive_w2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Bit-serial adder: the add-direction counterpart to the team's full subtractor.
- Takes two WIDTH-bit operands and a carry-in, then processes one bit per clock, LSB first, through a single 1-bit full-adder cell and a carry flip-flop.
- Presents a parallel sum and carry-out with a one-cycle done pulse.
- Sits beside the combinational subtract path as the low-area arithmetic option for datapaths.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous, active-high reset
- start  input   1      request to add; sampled only in IDLE
- a      input   WIDTH  minuend-side operand (augend), captured on accepted start
- b      input   WIDTH  addend, captured on accepted start
- cin    input   1      carry-in, captured on accepted start
- busy   output  1      high while bits are being processed (SHIFT state)
- done   output  1      one-cycle pulse: sum/cout valid
- sum    output  WIDTH  result, held until the next accepted start
- cout   output  1      final carry-out, held with sum

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. No asynchronous reset anywhere in the block.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, internal shift registers=0, carry flop=0.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - If start=1 at a rising edge: load a and b into shift registers, carry flop<=cin, counter<=0, sum<=0, cout<=0, go to SHIFT.
  - Otherwise stay in IDLE. Outputs hold their previous values.
- SHIFT, at each edge:
  - Full-add cell inputs: a_sh[0], b_sh[0], carry.
  - The sum bit shifts into sum from the MSB side (sum <= {s, sum[WIDTH-1:1]}).
  - carry <= carry-out of the cell.
  - a_sh and b_sh shift right by 1.
  - counter increments.
  - On the edge where counter==WIDTH-1 the last bit is processed: cout <= cell carry-out, go to DONE.
- DONE: done=1 for exactly this cycle. At the next edge go to IDLE unconditionally.
- Latency:
  - Start accepted at edge k.
  - Result valid and done=1 between edges k+WIDTH and k+WIDTH+1.
  - The earliest next accept is edge k+WIDTH+2 (start must be high in IDLE).
- busy=1 exactly in SHIFT (WIDTH cycles per operation). done and busy are never high together.
- start in SHIFT or DONE is ignored; it is not queued. a, b and cin may change freely after the accept edge.
- Arithmetic:
  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned, no overflow flag.
  - For two's-complement use, cout is ignored by the consumer.
- Reset mid-operation: rst=1 at any edge in any state forces the reset values at that edge. No done pulse is produced for the aborted operation.
- rst and start high at the same edge: rst wins, the operation is not accepted.
- Counter width is $clog2(WIDTH). It never exceeds WIDTH-1; no wrap is needed, because the exit is from the WIDTH-1 compare.

Decomposition:
- Shared package bsa_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - localparam for the default width
- One natural sub-module: full_add_cell, a combinational 1-bit full adder.
  - Inputs x, y, ci. Outputs s = x^y^ci and co = (x&y)|(ci&(x^y)).
  - Instantiated once inside the serial datapath.
- The FSM, counter and shift registers stay in the top module.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulsed 1 cycle -> busy high 8 cycles, then done=1 for 1 cycle with sum=8'h10, cout=0. A second start 1 cycle after done is accepted.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start held high continuously with a=8'h55, b=8'hAA, cin=0:
  - first result sum=8'hFF, cout=0.
  - operand changes during SHIFT have no effect.
  - accepts occur only every WIDTH+2 cycles.
- rst asserted on the 4th SHIFT cycle of a=8'h3C, b=8'h0F -> next cycle busy=0, done=0, sum=8'h00, cout=0, and no done pulse follows.
- Exhaustive check with WIDTH=2: all 32 combinations of a, b, cin -> every {cout,sum} equals a+b+cin, with done exactly WIDTH cycles after each accept.
- rst and start high at the same edge -> stays IDLE, busy=0. With both released, a later start proceeds normally.
